// File: rtl/evt_engine_stream_merger_if.sv
// Handshake bundle between the N_IN event sources, the merger and the engine router.
// The merger connects through the slave modport and the source/sink side through master.
interface evt_engine_stream_merger_if #(
  parameter int N_IN  = 4,
  parameter int EVT_W = 32
);
  logic [N_IN-1:0]       enable_mask_i;
  logic [N_IN-1:0]       in_valid_i;
  logic [N_IN-1:0]       in_ready_o;
  logic [N_IN*EVT_W-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [EVT_W-1:0]      out_data_o;
  logic                  barrier_o;
  logic                  mismatch_o;
  logic                  busy_o;

  modport master (
    output enable_mask_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, barrier_o, mismatch_o, busy_o
  );

  modport slave (
    input  enable_mask_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, barrier_o, mismatch_o, busy_o
  );
endinterface

// File: rtl/evt_engine_stream_merger.sv
// Merges N_IN event streams into one engine-bound stream: spikes are interleaved
// round-robin, time/synch events form a barrier across all enabled inputs.
module evt_engine_stream_merger #(
  parameter int N_IN   = 4,
  parameter int EVT_W  = 32,
  parameter int OP_LSB = 28,
  parameter int OP_W   = 4
) (
  input logic clk_i,
  input logic rst_ni,
  evt_engine_stream_merger_if.slave stream
);
  localparam int PTR_W = $clog2(N_IN);

  // Opcode encodings of the engine event stream; only time-class codes matter here.
  localparam logic [OP_W-1:0] EVT_TIME  = OP_W'(5);
  localparam logic [OP_W-1:0] EVT_SYNCH = OP_W'(6);

  typedef enum logic {ARB, SEND} state_e;

  state_e            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [EVT_W-1:0]  out_data;
  logic              out_valid;
  logic              busy;
  logic              barrier_pulse;
  logic              mismatch_pulse;

  logic [N_IN-1:0]   is_time;
  logic [N_IN-1:0]   eligible_spike;
  logic [OP_W-1:0]   op;
  logic              barrier_ready;
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [EVT_W-1:0]  grant_data;
  logic [EVT_W-1:0]  low_data;
  logic              heads_differ;
  logic [N_IN-1:0]   in_ready;
  int                idx;

  always_comb begin
    op             = '0;
    is_time        = '0;
    eligible_spike = '0;
    for (int i = 0; i < N_IN; i++) begin
      op             = stream.in_data_i[i*EVT_W+OP_LSB +: OP_W];
      is_time[i]     = (op == EVT_TIME) || (op == EVT_SYNCH);
      eligible_spike[i] = stream.enable_mask_i[i] & stream.in_valid_i[i] & ~is_time[i];
    end
    barrier_ready = (|stream.enable_mask_i) &&
                    (&(~stream.enable_mask_i | (stream.in_valid_i & is_time)));
  end

  // Descending scan so the smallest offset from rr_ptr is the one that sticks.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (eligible_spike[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
    next_ptr = (grant_idx == PTR_W'(N_IN - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  always_comb begin
    grant_data   = '0;
    low_data     = '0;
    heads_differ = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (PTR_W'(i) == grant_idx) grant_data = stream.in_data_i[i*EVT_W +: EVT_W];
    end
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (stream.enable_mask_i[i]) low_data = stream.in_data_i[i*EVT_W +: EVT_W];
    end
    for (int i = 0; i < N_IN; i++) begin
      if (stream.enable_mask_i[i] && (stream.in_data_i[i*EVT_W +: EVT_W] != low_data))
        heads_differ = 1'b1;
    end
  end

  // Pops are combinational so a source sees its handshake in the grant cycle itself.
  always_comb begin
    in_ready = '0;
    if (state == ARB) begin
      if (grant_found)        in_ready[grant_idx] = 1'b1;
      else if (barrier_ready) in_ready = stream.enable_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ARB;
      rr_ptr         <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      barrier_pulse  <= 1'b0;
      mismatch_pulse <= 1'b0;
    end else begin
      barrier_pulse  <= 1'b0;
      mismatch_pulse <= 1'b0;
      case (state)
        ARB: begin
          if (grant_found) begin
            out_data  <= grant_data;
            rr_ptr    <= next_ptr;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end else if (barrier_ready) begin
            out_data       <= low_data;
            barrier_pulse  <= 1'b1;
            mismatch_pulse <= heads_differ;
            out_valid      <= 1'b1;
            busy           <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          if (stream.out_ready_i) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ARB;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ARB;
        end
      endcase
    end
  end

  assign stream.in_ready_o  = in_ready;
  assign stream.out_valid_o = out_valid;
  assign stream.out_data_o  = out_data;
  assign stream.barrier_o   = barrier_pulse;
  assign stream.mismatch_o  = mismatch_pulse;
  assign stream.busy_o      = busy;
endmodule

// File: tb/tb_evt_engine_stream_merger.sv
// Directed bench for evt_engine_stream_merger: per-input source FIFOs feed the DUT,
// outputs are logged per cycle and each scenario task checks its own expectations.
module tb_evt_engine_stream_merger;
  localparam int N_IN  = 4;
  localparam int EVT_W = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [N_IN-1:0]       mask;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN*EVT_W-1:0] in_data;
  logic                  out_ready;

  evt_engine_stream_merger_if #(.N_IN(N_IN), .EVT_W(EVT_W)) bus ();

  assign bus.enable_mask_i = mask;
  assign bus.in_valid_i    = in_valid;
  assign bus.in_data_i     = in_data;
  assign bus.out_ready_i   = out_ready;

  evt_engine_stream_merger #(.N_IN(N_IN), .EVT_W(EVT_W), .OP_LSB(28), .OP_W(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .stream (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] src_mem [N_IN][16];
  int          src_wr [N_IN];
  int          src_rd [N_IN];

  logic [31:0] out_log [$];
  int          out_cyc [$];
  logic [3:0]  pop_log [$];
  int          pop_cyc [$];
  int          bar_cnt;
  int          mis_cnt;
  logic [31:0] bar_data;

  task automatic drive_inputs();
    for (int i = 0; i < N_IN; i++) begin
      in_valid[i] = (src_rd[i] < src_wr[i]);
      in_data[i*EVT_W +: EVT_W] = (src_rd[i] < src_wr[i]) ? src_mem[i][src_rd[i]] : 32'h0;
    end
  endtask

  task automatic push(input int i, input logic [31:0] d);
    src_mem[i][src_wr[i]] = d;
    src_wr[i] = src_wr[i] + 1;
    drive_inputs();
  endtask

  task automatic flush();
    for (int i = 0; i < N_IN; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    drive_inputs();
  endtask

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    pop_log.delete();
    pop_cyc.delete();
    bar_cnt  = 0;
    mis_cnt  = 0;
    bar_data = '0;
  endtask

  // Observe at the falling edge, then retire popped words just after the rising edge.
  task automatic tick();
    logic [N_IN-1:0] pops;
    @(negedge clk_i);
    pops = bus.in_ready_o;
    if (bus.out_valid_o && bus.out_ready_i) begin
      out_log.push_back(bus.out_data_o);
      out_cyc.push_back(cyc);
    end
    if (bus.barrier_o) begin
      bar_cnt++;
      bar_data = bus.out_data_o;
    end
    if (bus.mismatch_o) mis_cnt++;
    if (pops != '0) begin
      pop_log.push_back(pops);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N_IN; i++) if (pops[i]) src_rd[i] = src_rd[i] + 1;
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until(input int n, input int max_cycles, output bit ok);
    for (int c = 0; c < max_cycles && out_log.size() < n; c++) tick();
    ok = (out_log.size() >= n);
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    mask      = 4'b1111;
    out_ready = 1'b0;
    flush();
    clear_logs();
    #3;
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
    checks++; if (bus.out_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0", bus.out_data_o); end
    checks++; if (bus.in_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0000", bus.in_ready_o); end
    checks++; if (bus.barrier_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_barrier got %b want 0", bus.barrier_o); end
    checks++; if (bus.mismatch_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mismatch got %b want 0", bus.mismatch_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy_o); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL reset_rr_ptr got %0d want 0", dut.rr_ptr); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_round_robin();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < N_IN; i++) push(i, 32'h1000_0000 | i);
    run_until(4, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_timeout got %0d outputs want 4", out_log.size()); end
    for (int k = 0; k < 4 && k < out_log.size() && k < pop_log.size(); k++) begin
      checks++; if (out_log[k] !== (32'h1000_0000 | k)) begin errors++; $display("[TB] FAIL rr_data[%0d] got %h want %h", k, out_log[k], 32'h1000_0000 | k); end
      checks++; if (pop_log[k] !== 4'(1 << k)) begin errors++; $display("[TB] FAIL rr_pop[%0d] got %b want %b", k, pop_log[k], 4'(1 << k)); end
      checks++; if (out_cyc[k] !== pop_cyc[k] + 1) begin errors++; $display("[TB] FAIL rr_latency[%0d] got %0d want %0d", k, out_cyc[k], pop_cyc[k] + 1); end
      checks++; if (pop_cyc[k] !== pop_cyc[0] + 2 * k) begin errors++; $display("[TB] FAIL rr_spacing[%0d] got %0d want %0d", k, pop_cyc[k], pop_cyc[0] + 2 * k); end
    end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL rr_ptr_wrap got %0d want 0", dut.rr_ptr); end
  endtask

  task automatic test_barrier();
    bit ok;
    logic [31:0] exp_spk [6];
    exp_spk = '{32'h1000_0010, 32'h1000_0020, 32'h1000_0030,
                32'h1000_0011, 32'h1000_0021, 32'h1000_0031};
    flush();
    clear_logs();
    push(0, 32'h5000_0010);
    for (int i = 1; i < N_IN; i++) begin
      push(i, 32'h1000_0000 | (i << 4));
      push(i, 32'h1000_0001 | (i << 4));
    end
    run_until(6, 60, ok);
    for (int c = 0; c < 5; c++) tick();
    checks++; if (!ok || out_log.size() != 6) begin errors++; $display("[TB] FAIL bar_spike_count got %0d want 6", out_log.size()); end
    for (int k = 0; k < 6 && k < out_log.size(); k++) begin
      checks++; if (out_log[k] !== exp_spk[k]) begin errors++; $display("[TB] FAIL bar_spike[%0d] got %h want %h", k, out_log[k], exp_spk[k]); end
    end
    checks++; if (bar_cnt != 0) begin errors++; $display("[TB] FAIL bar_early got %0d pulses want 0", bar_cnt); end
    checks++; if (src_rd[0] != 0) begin errors++; $display("[TB] FAIL bar_time_popped got %0d want 0", src_rd[0]); end
    checks++; if (bus.in_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL bar_wait_ready got %b want 0000", bus.in_ready_o); end
    for (int i = 1; i < N_IN; i++) push(i, 32'h5000_0010);
    run_until(7, 20, ok);
    tick();
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bar_timeout got %0d outputs want 7", out_log.size()); end
    if (out_log.size() >= 7) begin
      checks++; if (out_log[6] !== 32'h5000_0010) begin errors++; $display("[TB] FAIL bar_data got %h want 50000010", out_log[6]); end
    end
    checks++; if (bar_cnt != 1) begin errors++; $display("[TB] FAIL bar_pulses got %0d want 1", bar_cnt); end
    checks++; if (mis_cnt != 0) begin errors++; $display("[TB] FAIL bar_mismatch got %0d want 0", mis_cnt); end
    checks++; if (pop_log.size() != 7 || pop_log[pop_log.size()-1] !== 4'b1111) begin errors++; $display("[TB] FAIL bar_pop_all got %0d pops want 7 ending 1111", pop_log.size()); end
  endtask

  task automatic test_mismatch();
    bit ok;
    flush();
    clear_logs();
    push(0, 32'h5000_0010);
    push(1, 32'h5000_0010);
    push(2, 32'h5000_0011);
    push(3, 32'h5000_0010);
    run_until(1, 20, ok);
    for (int c = 0; c < 3; c++) tick();
    checks++; if (!ok || out_log.size() != 1) begin errors++; $display("[TB] FAIL mis_count got %0d want 1", out_log.size()); end
    checks++; if (bar_data !== 32'h5000_0010) begin errors++; $display("[TB] FAIL mis_data got %h want 50000010", bar_data); end
    checks++; if (bar_cnt != 1) begin errors++; $display("[TB] FAIL mis_barrier_cycles got %0d want 1", bar_cnt); end
    checks++; if (mis_cnt != 1) begin errors++; $display("[TB] FAIL mis_pulse_cycles got %0d want 1", mis_cnt); end
  endtask

  task automatic test_mask();
    bit ok;
    flush();
    clear_logs();
    mask = 4'b0101;
    push(1, 32'h1000_00A1);
    push(3, 32'h1000_00A3);
    push(0, 32'h6000_0020);
    push(2, 32'h6000_0020);
    run_until(1, 20, ok);
    for (int c = 0; c < 4; c++) tick();
    checks++; if (!ok || out_log.size() != 1) begin errors++; $display("[TB] FAIL mask_count got %0d want 1", out_log.size()); end
    if (out_log.size() >= 1) begin
      checks++; if (out_log[0] !== 32'h6000_0020) begin errors++; $display("[TB] FAIL mask_data got %h want 60000020", out_log[0]); end
    end
    checks++; if (pop_log.size() != 1 || pop_log[0] !== 4'b0101) begin errors++; $display("[TB] FAIL mask_pops got %0d pops want one 0101", pop_log.size()); end
    checks++; if (bar_cnt != 1 || mis_cnt != 0) begin errors++; $display("[TB] FAIL mask_flags got bar=%0d mis=%0d want 1 0", bar_cnt, mis_cnt); end
    checks++; if (src_rd[1] != 0 || src_rd[3] != 0) begin errors++; $display("[TB] FAIL mask_disabled_popped got %0d %0d want 0 0", src_rd[1], src_rd[3]); end
    mask = 4'b1111;
    flush();
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    push(0, 32'h1000_00B0);
    for (int c = 0; c < 20 && pop_log.size() < 1; c++) tick();
    checks++; if (pop_log.size() != 1) begin errors++; $display("[TB] FAIL bp_pop got %0d pops want 1", pop_log.size()); end
    push(1, 32'h1000_00B1);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({bus.out_valid_o, bus.busy_o, bus.in_ready_o, bus.out_data_o} !== {1'b1, 1'b1, 4'b0000, 32'h1000_00B0}) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d] got v=%b b=%b r=%b d=%h want 1 1 0000 100000b0", c, bus.out_valid_o, bus.busy_o, bus.in_ready_o, bus.out_data_o);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_log.size() != 1) begin errors++; $display("[TB] FAIL bp_release got %0d handshakes want 1", out_log.size()); end
    checks++; if ({bus.out_valid_o, bus.busy_o, bus.in_ready_o} !== {1'b0, 1'b0, 4'b0010}) begin errors++; $display("[TB] FAIL bp_back_to_arb got v=%b b=%b r=%b want 0 0 0010", bus.out_valid_o, bus.busy_o, bus.in_ready_o); end
    run_until(2, 10, ok);
    checks++; if (!ok || out_log[0] !== 32'h1000_00B0 || out_log[1] !== 32'h1000_00B1) begin errors++; $display("[TB] FAIL bp_order got %0d outputs want b0 then b1", out_log.size()); end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    flush();
    clear_logs();
    out_ready = 1'b0;
    push(2, 32'h1000_00C2);
    for (int c = 0; c < 20 && pop_log.size() < 1; c++) tick();
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_send_entry got %b want 1", bus.out_valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_async got v=%b b=%b want 0 0", bus.out_valid_o, bus.busy_o); end
    checks++; if (bus.out_data_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got %h want 0", bus.out_data_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    flush();
    clear_logs();
    out_ready = 1'b1;
    push(3, 32'h1000_00C3);
    push(0, 32'h1000_00C0);
    run_until(2, 20, ok);
    checks++; if (!ok || out_log[0] !== 32'h1000_00C0 || out_log[1] !== 32'h1000_00C3) begin errors++; $display("[TB] FAIL rst_first_grant got %0d outputs want c0 then c3", out_log.size()); end
    checks++; if (pop_log.size() < 1 || pop_log[0] !== 4'b0001) begin errors++; $display("[TB] FAIL rst_first_pop got %0d pops want first 0001", pop_log.size()); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_barrier();
    test_mismatch();
    test_mask();
    test_backpressure();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/evt_engine_stream_merger.md
Name: evt_engine_stream_merger

Overview:
- Merges N_IN independent event streams into the single engine-bound stream that feeds the engine router.
- Spike-class events (any opcode other than EVT_TIME and EVT_SYNCH) are interleaved by round-robin arbitration.
- Time-class events (EVT_TIME, EVT_SYNCH) act as a barrier. Exactly one time event is forwarded, and only once every enabled input presents a time-class head. This keeps per-timestep ordering consistent across sources.

Parameters:
- N_IN, 4, number of input streams (>=2).
- EVT_W, 32, event word width.
- OP_LSB, 28, LSB of the operation field inside the event word.
- OP_W, 4, width of the operation field; compared against sne_evt_stream_pkg opcodes.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- enable_mask_i  in  N_IN  per-input participation enable; sampled only in state ARB
- in_valid_i  in  N_IN  input stream valid
- in_ready_o  out  N_IN  input stream ready (pop strobe)
- in_data_i  in  N_IN*EVT_W  input events; input i occupies bits [i*EVT_W +: EVT_W]
- out_valid_o  out  1  merged stream valid
- out_ready_i  in  1  merged stream ready
- out_data_o  out  EVT_W  merged event (registered)
- barrier_o  out  1  one-cycle pulse when a time barrier is taken
- mismatch_o  out  1  one-cycle pulse when barrier heads differ
- busy_o  out  1  high while in state SEND

Behaviour:
- Reset values: PS=ARB, rr_ptr=0, out_data_o=0, out_valid_o=0, in_ready_o=0, barrier_o=0, mismatch_o=0, busy_o=0.
- Head classification: head i is time-class if op(i) is EVT_TIME or EVT_SYNCH. It is spike-class otherwise, including EVT_IDLE and undefined opcodes.
- Eligibility:
  - eligible_spike[i] = enable_mask_i[i] & in_valid_i[i] & spike-class(i).
  - barrier_ready = (enable_mask_i != 0) & for every enabled i: in_valid_i[i] & time-class(i).
- State ARB (out_valid_o=0):
  - If any eligible_spike: grant the first eligible index searching from rr_ptr upward with wrap. Assert in_ready_o[g] combinationally this cycle. Register in_data_i[g] into out_data_o. Set rr_ptr = (g+1) mod N_IN. Go to SEND.
  - Else if barrier_ready: assert in_ready_o for all enabled inputs this cycle, popping all of them simultaneously. Register data of the lowest enabled index. Pulse barrier_o. Pulse mismatch_o if any enabled head word differs from the registered word. rr_ptr unchanged. Go to SEND.
  - Else stay. All in_ready_o=0.
  - Spike events always win over a barrier. An input parked on a time-class head is never popped until the barrier fires.
- State SEND:
  - out_valid_o=1, busy_o=1, all in_ready_o=0.
  - out_data_o is stable until out_ready_i=1; then return to ARB.
- Latency and throughput:
  - Input handshake in cycle t gives out_valid_o=1 at t+1.
  - Peak rate is one event per 2 cycles. The downstream router is multi-cycle per event, so this is acceptable.
- enable_mask_i:
  - A disabled input is never popped (ready=0) and is excluded from the barrier.
  - A mask change during SEND takes effect at the next ARB.
  - Mask all-zero: nothing granted, block idles in ARB.
- Valid with no ready: inputs may deassert in_valid_i without penalty. No state is held per input.
- Reset mid-operation: any pending out_data_o is discarded, rr_ptr returns to 0, outputs take reset values on the next edge. No partial pops are possible because pops complete within one cycle.
- Width rules:
  - rr_ptr is $clog2(N_IN) bits, wrap via mod N_IN; must be correct for non-power-of-2 N_IN.
  - The operation field is extracted as data[OP_LSB +: OP_W].

Test Plan:
1. Reset, mask=4'b1111. Inputs 0..3 each present one EVT_SPIKE word (0x1000_0000 | i), out_ready_i=1 -> outputs in order 0,1,2,3. Each in_ready_o pulses one cycle; out_valid_o high every 2nd cycle; rr_ptr back to 0.
2. Input 0 holds EVT_TIME 0x5000_0010; inputs 1-3 each send two spikes -> six spikes forwarded first. The time event is emitted only when inputs 1-3 also present EVT_TIME 0x5000_0010. barrier_o pulses once; all four ready pulse the same cycle; mismatch_o=0.
3. Barrier with input 2 head 0x5000_0011 and others 0x5000_0010 -> out_data_o=0x5000_0010, barrier_o=1 and mismatch_o=1 for exactly one cycle.
4. mask=4'b0101: inputs 1 and 3 valid with spikes, inputs 0 and 2 with EVT_SYNCH -> no pops of 1 and 3; a single barrier on inputs 0 and 2 is emitted immediately.
5. Backpressure: out_ready_i=0 for 10 cycles during SEND -> out_data_o constant, all in_ready_o=0, busy_o=1. Release gives one handshake, then return to ARB.
6. Assert rst_ni low during SEND -> out_valid_o=0 asynchronously. After release the first grant goes to input 0 (rr_ptr=0).
